// File: rtl/dmem_access_unit.sv
// dmem_access_unit
// Load/store sequencer sitting in front of the single-port DCache block RAM.
// It takes one byte-addressed request at a time and turns it into word
// accesses on the DCache port. Sub-word stores are done as read-modify-write.
// Loads are sign- or zero-extended. Misaligned and out-of-range requests
// complete with an error and never touch the RAM.

module dmem_access_unit #(
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              dc_en,
  output logic              dc_we,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [31:0]       dc_din,
  input  logic [31:0]       dc_dout
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ERR    = 3'd1,
    ST_ACCESS = 3'd2,
    ST_WAIT   = 3'd3,
    ST_MERGE  = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  state_t            state_r;
  state_t            next_state_s;

  // Fields captured at acceptance; only the in-range address bits are kept
  // because the range check has already been applied to the full address.
  logic              we_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [ADDR_W+1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdword_r;
  logic [CNT_W-1:0]  wait_cnt_r;

  logic              resp_valid_r;
  logic              resp_err_r;
  logic [31:0]       resp_rdata_r;

  logic              accept_s;
  logic              last_wait_s;
  logic              word_store_s;
  logic              dc_en_s;
  logic              dc_we_s;
  logic [ADDR_W-1:0] dc_addr_s;
  logic [31:0]       dc_din_s;

  // Returns 1 when a request is misaligned, has an illegal size or lies
  // beyond the DCache address space.
  function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr);
    logic align_bad;
    logic range_bad;
    case (size)
      2'b00:   align_bad = 1'b0;
      2'b01:   align_bad = addr[0];
      2'b10:   align_bad = (addr[1:0] != 2'b00);
      default: align_bad = 1'b1;
    endcase
    range_bad = ((addr >> (ADDR_W + 2)) != 32'd0);
    return align_bad | range_bad;
  endfunction

  // Replaces the addressed byte/halfword lane of old_word with the low bits
  // of new_data (little-endian lane numbering).
  function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                             input logic [31:0] new_data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] res;
    res = old_word;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   res[7:0]   = new_data[7:0];
          2'b01:   res[15:8]  = new_data[7:0];
          2'b10:   res[23:16] = new_data[7:0];
          default: res[31:24] = new_data[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) begin
          res[31:16] = new_data[15:0];
        end else begin
          res[15:0] = new_data[15:0];
        end
      end
      2'b10:   res = new_data;
      default: res = old_word;
    endcase
    return res;
  endfunction

  // Picks the addressed lane out of a fetched word and extends it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign req_ready    = (state_r == ST_IDLE) && !rst;
  assign accept_s     = req_valid && req_ready;
  assign last_wait_s  = (wait_cnt_r == CNT_W'(READ_LAT - 1));
  assign word_store_s = we_r && (size_r == 2'b10);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = req_bad(req_size, req_addr) ? ST_ERR : ST_ACCESS;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ERR:    next_state_s = ST_RESP;
      ST_ACCESS: begin
        if (word_store_s) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (last_wait_s) begin
          next_state_s = we_r ? ST_MERGE : ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_MERGE:  next_state_s = ST_RESP;
      ST_RESP:   next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Capture the request fields on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      uns_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
    end else if (accept_s) begin
      we_r    <= req_we;
      size_r  <= req_size;
      uns_r   <= req_unsigned;
      addr_r  <= req_addr[ADDR_W+1:0];
      wdata_r <= req_wdata;
    end else begin
      we_r    <= we_r;
      size_r  <= size_r;
      uns_r   <= uns_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Count read-latency cycles and capture the RAM word on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
      rdword_r   <= 32'd0;
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      rdword_r   <= last_wait_s ? dc_dout : rdword_r;
    end else begin
      wait_cnt_r <= '0;
      rdword_r   <= rdword_r;
    end
  end

  // Response registers, loaded on the transition into RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
    end else begin
      resp_valid_r <= (next_state_s == ST_RESP);
      resp_err_r   <= (next_state_s == ST_RESP) && (state_r == ST_ERR);
      if (next_state_s == ST_RESP) begin
        if ((state_r == ST_WAIT) && !we_r) begin
          resp_rdata_r <= load_extend(dc_dout, size_r, addr_r[1:0], uns_r);
        end else begin
          resp_rdata_r <= 32'd0;
        end
      end else begin
        resp_rdata_r <= resp_rdata_r;
      end
    end
  end

  // DCache port drive; held quiet during reset so no write slips through.
  always_comb begin
    dc_en_s   = 1'b0;
    dc_we_s   = 1'b0;
    dc_addr_s = '0;
    dc_din_s  = 32'd0;
    if (rst) begin
      dc_en_s = 1'b0;
      dc_we_s = 1'b0;
    end else begin
      case (state_r)
        ST_ACCESS: begin
          dc_en_s   = 1'b1;
          dc_addr_s = addr_r[ADDR_W+1:2];
          if (word_store_s) begin
            dc_we_s  = 1'b1;
            dc_din_s = wdata_r;
          end else begin
            dc_we_s  = 1'b0;
            dc_din_s = 32'd0;
          end
        end
        ST_MERGE: begin
          dc_en_s   = 1'b1;
          dc_we_s   = 1'b1;
          dc_addr_s = addr_r[ADDR_W+1:2];
          dc_din_s  = merge_lane(rdword_r, wdata_r, size_r, addr_r[1:0]);
        end
        default: begin
          dc_en_s = 1'b0;
          dc_we_s = 1'b0;
        end
      endcase
    end
  end

  assign dc_en      = dc_en_s;
  assign dc_we      = dc_we_s;
  assign dc_addr    = dc_addr_s;
  assign dc_din     = dc_din_s;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural one-cycle DCache.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        dc_en;
  logic        dc_we;
  logic [15:0] dc_addr;
  logic [31:0] dc_din;
  logic [31:0] dc_dout;

  logic [31:0] mem [0:65535];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.ADDR_W(16), .READ_LAT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .dc_en        (dc_en),
    .dc_we        (dc_we),
    .dc_addr      (dc_addr),
    .dc_din       (dc_din),
    .dc_dout      (dc_dout)
  );

  // Single-port read-first block RAM, one cycle read latency.
  always @(posedge clk) begin
    if (dc_en === 1'b1) begin
      if (dc_we === 1'b1) mem[dc_addr] <= dc_din;
      dc_dout <= mem[dc_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated request; watches ten cycles after acceptance.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_we, input logic [15:0] exp_dcaddr);
    int lat, nresp, nen, nwe;
    logic [15:0] seen_addr;
    logic [31:0] rdata;
    logic err, ready_after;
    lat = -1; nresp = 0; nen = 0; nwe = 0;
    seen_addr = 16'h0000; rdata = 32'h0; err = 1'b0; ready_after = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    check({tag, "/ready"}, {31'd0, req_ready}, 32'd1);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
        req_unsigned = ~uns;
      end
      if (dc_en === 1'b1) begin
        nen++;
        if (nen == 1) seen_addr = dc_addr;
      end
      if (dc_en === 1'b1 && dc_we === 1'b1) nwe++;
      if (n == lat + 1) ready_after = req_ready;
      if (resp_valid === 1'b1) begin
        nresp++;
        if (lat < 0) begin
          lat = n; err = resp_err; rdata = resp_rdata;
        end
      end
    end
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/resp_count"}, nresp, 32'd1);
    check({tag, "/resp_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "/resp_rdata"}, rdata, exp_rdata);
    check({tag, "/we_pulses"}, nwe, exp_we);
    if (exp_err) check({tag, "/dc_en_cycles"}, nen, 32'd0);
    else         check({tag, "/dc_addr"}, {16'd0, seen_addr}, {16'd0, exp_dcaddr});
    check({tag, "/ready_after"}, {31'd0, ready_after}, 32'd1);
  endtask

  initial begin
    int nresp, r1, r2;
    logic [15:0] seen_addr;
    logic [31:0] rd2;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    // Reset
    repeat (3) @(negedge clk);
    check("rst/ready_low", {31'd0, req_ready}, 32'd0);
    check("rst/dc_en_low", {31'd0, dc_en}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst/ready",      {31'd0, req_ready},  32'd1);
    check("rst/resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst/resp_err",   {31'd0, resp_err},   32'd0);
    check("rst/resp_rdata", resp_rdata,          32'd0);
    check("rst/dc_en",      {31'd0, dc_en},      32'd0);
    check("rst/dc_we",      {31'd0, dc_we},      32'd0);
    check("rst/dc_addr",    {16'd0, dc_addr},    32'd0);
    check("rst/dc_din",     dc_din,              32'd0);

    // Word store / load
    do_req("sw_deadbeef", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1, 16'h0004);
    check("mem_deadbeef", mem[4], 32'hDEADBEEF);
    do_req("lw_deadbeef", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, 0, 16'h0004);

    // Byte store read-modify-write
    do_req("sw_11223344", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 2, 1'b0, 32'h0, 1, 16'h0004);
    do_req("sb_ab", 1'b1, 2'b00, 1'b0, 32'h13, 32'h123456AB, 4, 1'b0, 32'h0, 1, 16'h0004);
    check("mem_ab223344", mem[4], 32'hAB223344);
    do_req("lb_s_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 3, 1'b0, 32'hFFFFFFAB, 0, 16'h0004);
    do_req("lbu_13",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 3, 1'b0, 32'h000000AB, 0, 16'h0004);

    // Halfword store read-modify-write
    do_req("sh_8001", 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF8001, 4, 1'b0, 32'h0, 1, 16'h0004);
    check("mem_80013344", mem[4], 32'h80013344);
    do_req("lh_s_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 3, 1'b0, 32'hFFFF8001, 0, 16'h0004);
    do_req("lhu_10",  1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 3, 1'b0, 32'h00003344, 0, 16'h0004);
    do_req("lb_s_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 3, 1'b0, 32'h00000033, 0, 16'h0004);
    do_req("lb_s_13b",1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 3, 1'b0, 32'hFFFFFF80, 0, 16'h0004);

    // Error requests
    do_req("err_lw_22",   1'b0, 2'b10, 1'b0, 32'h22,       32'h0, 2, 1'b1, 32'h0, 0, 16'h0);
    do_req("err_lh_11",   1'b0, 2'b01, 1'b0, 32'h11,       32'h0, 2, 1'b1, 32'h0, 0, 16'h0);
    do_req("err_size11",  1'b0, 2'b11, 1'b0, 32'h10,       32'h0, 2, 1'b1, 32'h0, 0, 16'h0);
    do_req("err_range",   1'b0, 2'b00, 1'b0, 32'h00040000, 32'h0, 2, 1'b1, 32'h0, 0, 16'h0);
    do_req("err_sh_13",   1'b1, 2'b01, 1'b0, 32'h13, 32'h0000BEEF, 2, 1'b1, 32'h0, 0, 16'h0);
    check("mem_after_err", mem[4], 32'h80013344);

    // Reset during the MERGE write of a byte store
    do_req("sw_55555555", 1'b1, 2'b10, 1'b0, 32'h20, 32'h55555555, 2, 1'b0, 32'h0, 1, 16'h0008);
    nresp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h000000AA;
    @(negedge clk); req_valid = 1'b0; nresp += int'(resp_valid);
    @(negedge clk); nresp += int'(resp_valid);
    @(negedge clk);
    check("rstmerge/in_merge", {31'd0, dc_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmerge/dc_we", {31'd0, dc_we}, 32'd0);
    check("rstmerge/dc_en", {31'd0, dc_en}, 32'd0);
    @(negedge clk);
    nresp += int'(resp_valid);
    check("rstmerge/ready_in_rst", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmerge/ready_after", {31'd0, req_ready}, 32'd1);
    for (int n = 0; n < 4; n++) begin
      nresp += int'(resp_valid);
      @(negedge clk);
    end
    check("rstmerge/no_resp", nresp, 32'd0);
    check("rstmerge/mem", mem[8], 32'h55555555);
    do_req("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'h55555555, 0, 16'h0008);

    // Back-to-back with req_valid held high at the top word
    r1 = -1; r2 = -1; rd2 = 32'h0; seen_addr = 16'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0003FFFC; req_wdata = 32'hCAFEF00D;
    check("b2b/ready0", {31'd0, req_ready}, 32'd1);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin req_we = 1'b0; req_wdata = 32'h0; end
      if (n == 1) check("b2b/ready1", {31'd0, req_ready}, 32'd0);
      if (n == 2) check("b2b/ready2", {31'd0, req_ready}, 32'd0);
      if (n == 3) check("b2b/ready3", {31'd0, req_ready}, 32'd1);
      if (n == 4) req_valid = 1'b0;
      if (dc_en === 1'b1 && n == 1) seen_addr = dc_addr;
      if (resp_valid === 1'b1) begin
        if (r1 < 0) r1 = n;
        else if (r2 < 0) begin r2 = n; rd2 = resp_rdata; end
      end
    end
    check("b2b/dc_addr", {16'd0, seen_addr}, 32'h0000FFFF);
    check("b2b/store_lat", r1, 32'd2);
    check("b2b/load_resp", r2, 32'd6);
    check("b2b/load_data", rd2, 32'hCAFEF00D);
    check("b2b/mem", mem[16'hFFFF], 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
